c_gate_bus_reduce_v5_0: RTL

- Downstream consumer of the gate-bus stage's registered Q word.
- Folds a frame of C_FRAME_LEN consecutive words into one C_WIDTH result by bitwise AND, OR or XOR.
- Reports the population count of the result and flags framing errors.
- Feeds frame-level flag and mask checks in the datapath control.

---
 rtl/c_gate_bus_reduce_v5_0.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/c_gate_bus_reduce_v5_0.sv
`timescale 1ns/1ps
// c_gate_bus_reduce_v5_0
// Folds a frame of C_FRAME_LEN consecutive gate-bus words into one C_WIDTH
// result with a bitwise AND, OR or XOR, then reports the population count of
// that result and keeps a sticky framing-error flag.
//
// Ports:
//   CLK    - rising-edge clock
//   ACLR   - asynchronous active-high reset
//   CE     - clock enable (used only when C_HAS_CE=1)
//   SCLR   - synchronous clear (used only when C_HAS_SCLR=1)
//   D      - data word
//   ND     - D valid this cycle
//   SOF    - first word of a frame (qualified by ND)
//   RFD    - ready for data (low only while the frame is being closed)
//   RESULT - folded frame result, held until the next frame completes
//   ONES   - popcount of RESULT, valid with RDY
//   RDY    - one-cycle pulse when RESULT/ONES are valid (stretches while CE=0)
//   CNT    - words accumulated in the current frame
//   ERR    - sticky framing error
//
// state | meaning
// IDLE  | waiting for a SOF word
// ACCUM | folding words into acc
// DONE  | RESULT loaded; computing ONES and raising RDY
module c_gate_bus_reduce_v5_0 #(
    parameter int C_WIDTH       = 16,
    parameter int C_ACC_TYPE    = 2,
    parameter int C_FRAME_LEN   = 8,
    parameter int C_ONES_WIDTH  = 5,
    parameter int C_HAS_CE      = 0,
    parameter int C_HAS_SCLR    = 0,
    parameter int C_SYNC_ENABLE = 0
) (
    input  logic                    CLK,
    input  logic                    ACLR,
    input  logic                    CE,
    input  logic                    SCLR,
    input  logic [C_WIDTH-1:0]      D,
    input  logic                    ND,
    input  logic                    SOF,
    output logic                    RFD,
    output logic [C_WIDTH-1:0]      RESULT,
    output logic [C_ONES_WIDTH-1:0] ONES,
    output logic                    RDY,
    output logic [7:0]              CNT,
    output logic                    ERR
);

    if (C_WIDTH < 1 || C_WIDTH > 64) begin : g_bad_width
        $fatal(1, "c_gate_bus_reduce_v5_0: C_WIDTH %0d out of range 1..64", C_WIDTH);
    end
    if (C_ACC_TYPE != 0 && C_ACC_TYPE != 2 && C_ACC_TYPE != 4) begin : g_bad_acc
        $fatal(1, "c_gate_bus_reduce_v5_0: C_ACC_TYPE %0d must be 0, 2 or 4", C_ACC_TYPE);
    end
    if (C_FRAME_LEN < 2 || C_FRAME_LEN > 255) begin : g_bad_len
        $fatal(1, "c_gate_bus_reduce_v5_0: C_FRAME_LEN %0d out of range 2..255", C_FRAME_LEN);
    end
    if ((2 ** C_ONES_WIDTH) <= C_WIDTH) begin : g_bad_ones
        $fatal(1, "c_gate_bus_reduce_v5_0: C_ONES_WIDTH %0d too narrow for C_WIDTH %0d",
               C_ONES_WIDTH, C_WIDTH);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [C_WIDTH-1:0] acc;
    logic [C_WIDTH-1:0] acc_op;
    logic [7:0]         cnt_nxt;
    logic               en;
    logic               do_clr;

    function automatic logic [C_ONES_WIDTH-1:0] popcount(input logic [C_WIDTH-1:0] v);
        logic [C_ONES_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < C_WIDTH; i++) begin
            n = n + C_ONES_WIDTH'(v[i]);
        end
        return n;
    endfunction

    assign en      = (C_HAS_CE != 0) ? CE : 1'b1;
    // Synchronous-enable mode lets CE gate the clear as well.
    assign do_clr  = (C_HAS_SCLR == 0)    ? 1'b0 :
                     (C_SYNC_ENABLE != 0) ? (SCLR & en) : SCLR;
    assign cnt_nxt = CNT + 8'd1;
    assign RFD     = (state != DONE);

    // Native SV bitwise operators already give the gate-bus X rules:
    // 0 dominates AND, 1 dominates OR, X poisons XOR.
    always_comb begin
        acc_op = acc ^ D;
        if (C_ACC_TYPE == 0) begin
            acc_op = acc & D;
        end else if (C_ACC_TYPE == 2) begin
            acc_op = acc | D;
        end
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            state  <= IDLE;
            acc    <= '0;
            CNT    <= '0;
            RESULT <= '0;
            ONES   <= '0;
            RDY    <= 1'b0;
            ERR    <= 1'b0;
        end else if (do_clr) begin
            state  <= IDLE;
            acc    <= '0;
            CNT    <= '0;
            RESULT <= '0;
            ONES   <= '0;
            RDY    <= 1'b0;
            ERR    <= 1'b0;
        end else if (en) begin
            RDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ND) begin
                        if (SOF) begin
                            acc   <= D;
                            CNT   <= 8'd1;
                            state <= ACCUM;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (ND) begin
                        if (SOF) begin
                            // Restart on the new frame; the old one never reaches RESULT.
                            acc <= D;
                            CNT <= 8'd1;
                            ERR <= 1'b1;
                        end else begin
                            acc <= acc_op;
                            if (cnt_nxt == 8'(C_FRAME_LEN)) begin
                                RESULT <= acc_op;
                                CNT    <= '0;
                                state  <= DONE;
                            end else begin
                                CNT <= cnt_nxt;
                            end
                        end
                    end
                end
                DONE: begin
                    ONES  <= popcount(RESULT);
                    RDY   <= 1'b1;
                    state <= IDLE;
                    if (ND) begin
                        ERR <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
